// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues word fetches to imem and queues {pc+4, instruction} pairs for ID.
// Latency: an acked word reaches the queue head on the cycle after imem_ack.
// Backpressure: id_ready low holds the head; fetching pauses while the queue is full. redirect flushes the queue.
//
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr/imem_ack/imem_rdata  - single-outstanding instruction memory port
//   redirect/redirect_pc                    - flush and refetch from a new address
//   id_ready/ins_valid/ins_out/pc_plus4_out - queue head towards the IF/ID register
//   count                                   - current occupancy 0..DEPTH
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        ins_valid,
    output logic [31:0] ins_out,
    output logic [31:0] pc_plus4_out,
    output logic [3:0]  count
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] ins;
    } entry_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      fpc;
    logic [31:0]      fpc_nxt;
    logic [31:0]      req_addr;
    logic [31:0]      req_addr_nxt;
    logic [31:0]      seq_addr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [3:0]       count_after_push;
    logic             push;
    logic             pop;
    logic             flush;
    entry_t           mem [DEPTH];
    entry_t           head;

    // Sequential successor of the outstanding request; wraps modulo 2^32.
    assign seq_addr  = req_addr + 32'd4;

    assign imem_req  = (state == WAIT) || (state == DROP);
    assign imem_addr = req_addr;

    assign ins_valid    = (count != 4'd0);
    assign head         = mem[rd_ptr];
    assign ins_out      = ins_valid ? head.ins      : 32'd0;
    assign pc_plus4_out = ins_valid ? head.pc_plus4 : 32'd0;

    // Redirect wins over both queue ports in the same cycle.
    assign flush = redirect;
    assign pop   = ins_valid && id_ready && !redirect;

    always_comb begin
        state_nxt        = state;
        fpc_nxt          = fpc;
        req_addr_nxt     = req_addr;
        push             = 1'b0;
        count_after_push = count + 4'd1 - {3'b000, pop};
        case (state)
            IDLE: begin
                if (redirect) begin
                    fpc_nxt = redirect_pc;
                end else if (count < DEPTH_C) begin
                    state_nxt    = WAIT;
                    req_addr_nxt = fpc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // With ack this cycle the data is simply dropped; without it
                    // the in-flight response must be absorbed in DROP.
                    fpc_nxt   = redirect_pc;
                    state_nxt = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push    = 1'b1;
                    fpc_nxt = seq_addr;
                    // Keep streaming only if the entry being pushed leaves room
                    // for the next response; guarantees no push into a full queue.
                    if (count_after_push < DEPTH_C) begin
                        req_addr_nxt = seq_addr;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fpc_nxt = redirect_pc;
                end
                // The stale response terminates the request; a redirect arriving
                // with it must not leave the FSM waiting for an ack that never comes.
                if (imem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fpc      <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fpc      <= fpc_nxt;
            req_addr <= req_addr_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc_plus4: seq_addr, ins: imem_rdata};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a latency-programmable instruction memory
// model returns addr ^ 32'h1234_5678 as the instruction word.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] pc_plus4_out;
    logic [3:0]  count;

    int checks;
    int failures;

    logic       mem_on;
    logic [3:0] mem_lat;
    logic [3:0] lat_cnt;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_ready     (id_ready),
        .ins_valid    (ins_valid),
        .ins_out      (ins_out),
        .pc_plus4_out (pc_plus4_out),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    // Memory acks on the mem_lat-th cycle of a request.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_cnt <= 4'd0;
        end else if (imem_req && !imem_ack) begin
            lat_cnt <= lat_cnt + 4'd1;
        end else begin
            lat_cnt <= 4'd0;
        end
    end

    assign imem_ack   = mem_on && imem_req && (lat_cnt == mem_lat - 4'd1);
    assign imem_rdata = imem_ack ? dat(imem_addr) : 32'hDEAD_BEEF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset low across one edge, releases mid-cycle; the next edge is the
    // first with reset high.
    task automatic do_reset(input logic [3:0] lat, input logic rdy);
        @(posedge clk);
        #2;
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        id_ready    = rdy;
        mem_on      = 1'b1;
        mem_lat     = lat;
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%h exp=0", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%h exp=0", ins_valid); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (ins_out !== 32'd0) begin failures++; $display("FAIL reset_ins got=%h exp=0", ins_out); end
        checks++; if (pc_plus4_out !== 32'd0) begin failures++; $display("FAIL reset_pc4 got=%h exp=0", pc_plus4_out); end
    endtask

    task automatic test_stream();
        do_reset(4'd1, 1'b1);
        step();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL stream_first_req got=%h exp=1", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL stream_first_addr got=%h exp=0", imem_addr); end
        checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL stream_first_valid got=%h exp=0", ins_valid); end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (imem_addr !== 32'(4 * i)) begin failures++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, imem_addr, 32'(4 * i)); end
            checks++; if (ins_out !== dat(32'(4 * (i - 1)))) begin failures++; $display("FAIL stream_ins[%0d] got=%h exp=%h", i, ins_out, dat(32'(4 * (i - 1)))); end
            checks++; if (pc_plus4_out !== 32'(4 * i)) begin failures++; $display("FAIL stream_pc4[%0d] got=%h exp=%h", i, pc_plus4_out, 32'(4 * i)); end
            checks++; if (count !== 4'd1) begin failures++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, count); end
        end
    endtask

    task automatic test_full();
        do_reset(4'd1, 1'b0);
        for (int i = 0; i < 6; i++) step();
        checks++; if (count !== 4'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL full_req got=%h exp=0", imem_req); end
        checks++; if (ins_out !== dat(32'd0)) begin failures++; $display("FAIL full_head got=%h exp=%h", ins_out, dat(32'd0)); end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL full_pop_count got=%0d exp=3", count); end
        checks++; if (pc_plus4_out !== 32'd8) begin failures++; $display("FAIL full_pop_pc4 got=%h exp=8", pc_plus4_out); end
        step();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL full_reissue_req got=%h exp=1", imem_req); end
        checks++; if (imem_addr !== 32'd16) begin failures++; $display("FAIL full_reissue_addr got=%h exp=10", imem_addr); end
        step();
        checks++; if (count !== 4'd4) begin failures++; $display("FAIL full_refill_count got=%0d exp=4", count); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL full_refill_req got=%h exp=0", imem_req); end
    endtask

    task automatic test_redirect_drop();
        do_reset(4'd3, 1'b1);
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL drop_req got=%h exp=1", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL drop_addr_hold got=%h exp=0", imem_addr); end
        step();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL drop_count got=%0d exp=0", count); end
        checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL drop_valid got=%h exp=0", ins_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL drop_idle_req got=%h exp=0", imem_req); end
        step();
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL drop_new_addr got=%h exp=100", imem_addr); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (pc_plus4_out !== 32'h104) begin failures++; $display("FAIL drop_new_pc4 got=%h exp=104", pc_plus4_out); end
        checks++; if (ins_out !== dat(32'h100)) begin failures++; $display("FAIL drop_new_ins got=%h exp=%h", ins_out, dat(32'h100)); end
    endtask

    task automatic test_redirect_ack_pop();
        do_reset(4'd1, 1'b1);
        step();
        step();
        checks++; if (!(ins_valid === 1'b1 && imem_ack === 1'b1)) begin failures++; $display("FAIL rap_setup got=%h%h exp=11", ins_valid, imem_ack); end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL rap_count got=%0d exp=0", count); end
        checks++; if (ins_out !== 32'd0) begin failures++; $display("FAIL rap_ins got=%h exp=0", ins_out); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rap_req got=%h exp=0", imem_req); end
        step();
        checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL rap_new_addr got=%h exp=200", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rap_new_req got=%h exp=1", imem_req); end
    endtask

    task automatic test_async_reset();
        do_reset(4'd1, 1'b0);
        step();
        step();
        step();
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL areset_setup got=%0d exp=2", count); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL areset_req got=%h exp=0", imem_req); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", count); end
        checks++; if (ins_out !== 32'd0) begin failures++; $display("FAIL areset_ins got=%h exp=0", ins_out); end
        checks++; if (pc_plus4_out !== 32'd0) begin failures++; $display("FAIL areset_pc4 got=%h exp=0", pc_plus4_out); end
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL areset_addr got=%h exp=0", imem_addr); end
        #1;
        reset = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL areset_first_req got=%h exp=1", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL areset_first_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset(4'd1, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wrap_idle_req got=%h exp=0", imem_req); end
        step();
        checks++; if (imem_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_addr0 got=%h exp=fffffff8", imem_addr); end
        step();
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr1 got=%h exp=fffffffc", imem_addr); end
        checks++; if (pc_plus4_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc4_0 got=%h exp=fffffffc", pc_plus4_out); end
        step();
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL wrap_addr2 got=%h exp=0", imem_addr); end
        checks++; if (pc_plus4_out !== 32'd0) begin failures++; $display("FAIL wrap_pc4_1 got=%h exp=0", pc_plus4_out); end
        checks++; if (ins_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%h exp=1", ins_valid); end
        checks++; if (ins_out !== dat(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_ins got=%h exp=%h", ins_out, dat(32'hFFFF_FFFC)); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        id_ready    = 1'b0;
        mem_on      = 1'b0;
        mem_lat     = 4'd1;
        #2;
        reset = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_redirect_drop();
        test_redirect_ack_pop();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
